// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller: floor geometry,
// direction encoding and the car FSM state type.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } car_state_t;

  // One-hot floor mask, bit n = floor n.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

endpackage

// File: rtl/elevator_target_select.sv
// Combinational view of the pending bitmap relative to a floor:
// is anything requested above, below, or exactly here.
module elevator_target_select
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  targets_above,
  output logic                  targets_below,
  output logic                  target_here
);

  // Classify every set pending bit against the reference floor.
  always_comb begin
    targets_above = 1'b0;
    targets_below = 1'b0;
    target_here   = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (i > int'(floor))      targets_above = 1'b1;
        else if (i < int'(floor)) targets_below = 1'b1;
        else                      target_here   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_car_controller.sv
// Single elevator car: accepts hall requests dispatched to this car and
// in-car calls, travels floor by floor and opens the door at targets.
// Optional feature macro: ELEV_DOOR_HOLD_EN adds a door_hold input that
// keeps the door open while asserted.
//
// Handshake: a hall request is a single-cycle offer (request_valid with
// dispatch_elev == ELEV_ID); it is always taken, and request_ack pulses on
// the following cycle. There is no backpressure.
//
// state_dbg exposes the FSM state (car_state_t encoding); last_req_dir
// holds the direction of the most recently accepted hall request.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter logic [1:0] ELEV_ID     = 2'b01,
  parameter int         FLOOR_TICKS = 4,
  parameter int         DOOR_TICKS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            dispatch_elev,
  input  logic                  request_valid,
  input  logic [FLOOR_W-1:0]    request_floor,
  input  logic                  request_dir,
  input  logic                  car_call_valid,
  input  logic [FLOOR_W-1:0]    car_call_floor,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic                  request_ack,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  current_dir,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            state_dbg,
  output logic                  last_req_dir
);

  // Counters run from N-1 down to 0, so a load covers exactly N cycles.
  localparam int TW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_TICKS - 1);

  car_state_t              state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    ack_q, ack_d;
  logic                    last_dir_q, last_dir_d;
  logic                    door_open_q, door_open_d;
  logic [TW-1:0]           travel_cnt_q, travel_cnt_d;
  logic [DW-1:0]           door_cnt_q, door_cnt_d;

  logic                    accept;
  logic                    arrive;
  logic [NUM_FLOORS-1:0]   pending_set;
  logic                    targets_above, targets_below, target_here;

  // Request intake and the floor the car occupies after this edge.
  always_comb begin
    accept      = request_valid && (dispatch_elev == ELEV_ID);
    pending_set = pending_q
                | (accept         ? floor_onehot(request_floor)  : '0)
                | (car_call_valid ? floor_onehot(car_call_floor) : '0);
    arrive      = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && (travel_cnt_q == '0);
    floor_d     = floor_q;
    if (arrive) begin
      floor_d = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    end
  end

  // Targets are judged at the arrival floor when a floor is reached,
  // otherwise at the current floor.
  elevator_target_select u_target_select (
    .pending       (pending_q),
    .floor         (floor_d),
    .targets_above (targets_above),
    .targets_below (targets_below),
    .target_here   (target_here)
  );

  // Car FSM next state, counters, direction and pending update.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;

    case (state_q)
      IDLE: begin
        if (target_here) begin
          state_d    = DOOR_OPEN;
          door_cnt_d = DOOR_LOAD;
        end else if ((dir_q == DIR_UP) && targets_above) begin
          state_d      = MOVE_UP;
          travel_cnt_d = TRAVEL_LOAD;
        end else if ((dir_q == DIR_DOWN) && targets_below) begin
          state_d      = MOVE_DOWN;
          travel_cnt_d = TRAVEL_LOAD;
        end else if ((dir_q == DIR_UP) && targets_below) begin
          dir_d        = DIR_DOWN;
          state_d      = MOVE_DOWN;
          travel_cnt_d = TRAVEL_LOAD;
        end else if ((dir_q == DIR_DOWN) && targets_above) begin
          dir_d        = DIR_UP;
          state_d      = MOVE_UP;
          travel_cnt_d = TRAVEL_LOAD;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (!arrive) begin
          travel_cnt_d = travel_cnt_q - TW'(1);
        end else if (target_here) begin
          state_d    = DOOR_OPEN;
          door_cnt_d = DOOR_LOAD;
        end else if ((state_q == MOVE_UP) ? targets_above : targets_below) begin
          travel_cnt_d = TRAVEL_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DOOR_OPEN: begin
`ifdef ELEV_DOOR_HOLD_EN
        if (door_hold) begin
          door_cnt_d = DOOR_LOAD;
        end else
`endif
        if (door_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          door_cnt_d = door_cnt_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The open door serves its own floor, so that bit is never left set,
    // including on the cycle the door closes.
    pending_d = pending_set;
    if ((state_d == DOOR_OPEN) || (state_q == DOOR_OPEN)) begin
      pending_d = pending_set & ~floor_onehot(floor_d);
    end

    ack_d       = accept;
    last_dir_d  = accept ? request_dir : last_dir_q;
    door_open_d = (state_d == DOOR_OPEN);
  end

  // All state and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      floor_q      <= '0;
      dir_q        <= DIR_UP;
      pending_q    <= '0;
      ack_q        <= 1'b0;
      last_dir_q   <= DIR_UP;
      door_open_q  <= 1'b0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      last_dir_q   <= last_dir_d;
      door_open_q  <= door_open_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  assign request_ack   = ack_q;
  assign current_floor = floor_q;
  assign current_dir   = dir_q;
  assign door_open     = door_open_q;
  assign pending       = pending_q;
  assign state_dbg     = state_q;
  assign last_req_dir  = last_dir_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller (ELEV_ID=01, FLOOR_TICKS=4, DOOR_TICKS=8).
// Single-cycle request handling from a vector table, then hand-written
// multi-cycle sequences for travel, stops, reversal, door absorption,
// reset mid-travel and (with ELEV_DOOR_HOLD_EN) door hold.
module tb_elevator_car_controller;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] dispatch_elev;
  logic       request_valid;
  logic [2:0] request_floor;
  logic       request_dir;
  logic       car_call_valid;
  logic [2:0] car_call_floor;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold;
`endif
  logic       request_ack;
  logic [2:0] current_floor;
  logic       current_dir;
  logic       door_open;
  logic [7:0] pending;
  logic [1:0] state_dbg;
  logic       last_req_dir;

  elevator_car_controller #(
    .ELEV_ID     (2'b01),
    .FLOOR_TICKS (4),
    .DOOR_TICKS  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dispatch_elev  (dispatch_elev),
    .request_valid  (request_valid),
    .request_floor  (request_floor),
    .request_dir    (request_dir),
    .car_call_valid (car_call_valid),
    .car_call_floor (car_call_floor),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold      (door_hold),
`endif
    .request_ack    (request_ack),
    .current_floor  (current_floor),
    .current_dir    (current_dir),
    .door_open      (door_open),
    .pending        (pending),
    .state_dbg      (state_dbg),
    .last_req_dir   (last_req_dir)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_elev  = 2'b00;
    request_valid  = 1'b0;
    request_floor  = 3'd0;
    request_dir    = 1'b0;
    car_call_valid = 1'b0;
    car_call_floor = 3'd0;
`ifdef ELEV_DOOR_HOLD_EN
    door_hold      = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic hall(input logic [2:0] f, input logic d);
    dispatch_elev = 2'b01;
    request_valid = 1'b1;
    request_floor = f;
    request_dir   = d;
  endtask

  task automatic call(input logic [2:0] f);
    car_call_valid = 1'b1;
    car_call_floor = f;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [1:0] disp;
    logic       rv;
    logic [2:0] rf;
    logic       rd;
    logic       cv;
    logic [2:0] cf;
    logic       e_ack;
    logic [2:0] e_floor;
    logic       e_dir;
    logic       e_door;
    logic [7:0] e_pend;
    logic [1:0] e_state;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  // ---------------- stimulus ----------------
  initial begin
    int door_cycles;
    int dir_flips;
    logic reached;

    rst_n = 1'b0;
    idle_inputs();

    //            rst disp  rv rf   rd cv cf     ack flr  dir door pend   state
    vecs[0]  = '{1'b0, 2'b00, 0, 3'd0, 0, 0, 3'd0,  0, 3'd0, 1, 0, 8'h00, ST_IDLE};
    vecs[1]  = '{1'b1, 2'b10, 1, 3'd5, 1, 0, 3'd0,  0, 3'd0, 1, 0, 8'h00, ST_IDLE};
    vecs[2]  = '{1'b1, 2'b11, 1, 3'd5, 1, 0, 3'd0,  0, 3'd0, 1, 0, 8'h00, ST_IDLE};
    vecs[3]  = '{1'b1, 2'b00, 1, 3'd5, 1, 0, 3'd0,  0, 3'd0, 1, 0, 8'h00, ST_IDLE};
    vecs[4]  = '{1'b1, 2'b00, 0, 3'd0, 0, 0, 3'd0,  0, 3'd0, 1, 0, 8'h00, ST_IDLE};
    vecs[5]  = '{1'b1, 2'b01, 1, 3'd6, 0, 1, 3'd2,  1, 3'd0, 1, 0, 8'h44, ST_IDLE};
    vecs[6]  = '{1'b1, 2'b00, 0, 3'd0, 0, 0, 3'd0,  0, 3'd0, 1, 0, 8'h44, ST_UP};
    vecs[7]  = '{1'b1, 2'b00, 0, 3'd0, 0, 1, 3'd2,  0, 3'd0, 1, 0, 8'h44, ST_UP};
    vecs[8]  = '{1'b1, 2'b01, 1, 3'd6, 1, 0, 3'd0,  1, 3'd0, 1, 0, 8'h44, ST_UP};
    vecs[9]  = '{1'b1, 2'b00, 0, 3'd0, 0, 0, 3'd0,  0, 3'd0, 1, 0, 8'h44, ST_UP};
    vecs[10] = '{1'b1, 2'b00, 0, 3'd0, 0, 0, 3'd0,  0, 3'd1, 1, 0, 8'h44, ST_UP};
    vecs[11] = '{1'b0, 2'b01, 1, 3'd4, 1, 0, 3'd0,  0, 3'd0, 1, 0, 8'h00, ST_IDLE};
    vecs[12] = '{1'b1, 2'b00, 0, 3'd0, 0, 1, 3'd0,  0, 3'd0, 1, 0, 8'h01, ST_IDLE};
    vecs[13] = '{1'b1, 2'b00, 0, 3'd0, 0, 0, 3'd0,  0, 3'd0, 1, 1, 8'h00, ST_DOOR};
    vecs[14] = '{1'b1, 2'b01, 1, 3'd0, 1, 0, 3'd0,  1, 3'd0, 1, 1, 8'h00, ST_DOOR};

    for (int i = 0; i < NVEC; i++) begin
      rst_n          = vecs[i].rst_n;
      dispatch_elev  = vecs[i].disp;
      request_valid  = vecs[i].rv;
      request_floor  = vecs[i].rf;
      request_dir    = vecs[i].rd;
      car_call_valid = vecs[i].cv;
      car_call_floor = vecs[i].cf;
      tick();
      check($sformatf("vec%0d_ack", i),   request_ack,   vecs[i].e_ack);
      check($sformatf("vec%0d_floor", i), current_floor, vecs[i].e_floor);
      check($sformatf("vec%0d_dir", i),   current_dir,   vecs[i].e_dir);
      check($sformatf("vec%0d_door", i),  door_open,     vecs[i].e_door);
      check($sformatf("vec%0d_pend", i),  pending,       vecs[i].e_pend);
      check($sformatf("vec%0d_state", i), state_dbg,     vecs[i].e_state);
    end

    // Hall request floor 3 up: ack, 12-cycle trip, 8-cycle door.
    do_reset();
    hall(3'd3, 1'b1);
    tick();
    idle_inputs();
    check("a_ack",      request_ack,  1);
    check("a_pend",     pending,      8'h08);
    check("a_last_dir", last_req_dir, 1);
    tick();
    check("a_ack_drop", request_ack, 0);
    check("a_move",     state_dbg,   ST_UP);
    repeat (11) tick();
    check("a_floor_before", current_floor, 2);
    check("a_door_before",  door_open,     0);
    tick();
    check("a_floor3", current_floor, 3);
    check("a_door",   door_open,     1);
    check("a_pend0",  pending,       8'h00);
    door_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!door_open) break;
      door_cycles++;
    end
    check("a_door_cycles", door_cycles, 8);
    check("a_idle",        state_dbg,   ST_IDLE);

    // Car call 5, then call 2 mid-way between floors 0 and 1.
    do_reset();
    call(3'd5);
    tick();
    idle_inputs();
    tick();
    tick();
    call(3'd2);
    tick();
    idle_inputs();
    check("b_pend", pending, 8'h24);
    repeat (6) tick();
    check("b_floor2", current_floor, 2);
    check("b_door2",  door_open,     1);
    check("b_pend2",  pending,       8'h20);
    dir_flips = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (current_dir !== 1'b1) dir_flips++;
    end
    check("b_dir_held", dir_flips,     0);
    check("b_floor5",   current_floor, 5);
    check("b_door5",    door_open,     1);
    check("b_pend5",    pending,       8'h00);

    // Parked at 4 going up, only floor 1 pending: reverse and go down.
    do_reset();
    call(3'd4);
    tick();
    idle_inputs();
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state_dbg == ST_IDLE && !door_open && current_floor == 3'd4) begin
        reached = 1'b1;
        break;
      end
    end
    check("c_reach_floor4", reached,     1);
    check("c_dir_up",       current_dir, 1);
    call(3'd1);
    tick();
    idle_inputs();
    check("c_pend",     pending,     8'h02);
    check("c_dir_hold", current_dir, 1);
    tick();
    check("c_dir_flip", current_dir, 0);
    check("c_move_dn",  state_dbg,   ST_DOWN);
    repeat (11) tick();
    check("c_floor_before", current_floor, 2);
    tick();
    check("c_floor1", current_floor, 1);
    check("c_door1",  door_open,     1);

    // Hall request for the floor whose door is already open.
    do_reset();
    call(3'd2);
    tick();
    idle_inputs();
    repeat (9) tick();
    check("d_door_open", door_open,     1);
    check("d_floor2",    current_floor, 2);
    hall(3'd2, 1'b0);
    tick();
    idle_inputs();
    check("d_ack",  request_ack, 1);
    check("d_pend", pending,     8'h00);
    repeat (6) tick();
    check("d_door_last", door_open, 1);
    tick();
    check("d_door_closed", door_open, 0);
    check("d_idle",        state_dbg, ST_IDLE);
    check("d_pend_after",  pending,   8'h00);
    tick();
    check("d_stay_idle", state_dbg, ST_IDLE);

    // Reset while travelling between floors 3 and 4.
    do_reset();
    call(3'd7);
    tick();
    idle_inputs();
    repeat (14) tick();
    check("e_floor3", current_floor, 3);
    check("e_moving", state_dbg,     ST_UP);
    rst_n = 1'b0;
    hall(3'd5, 1'b1);
    tick();
    check("e_rst_floor", current_floor, 0);
    check("e_rst_pend",  pending,       8'h00);
    check("e_rst_state", state_dbg,     ST_IDLE);
    check("e_rst_ack",   request_ack,   0);
    check("e_rst_dir",   current_dir,   1);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    check("e_post_ack",   request_ack, 0);
    check("e_post_state", state_dbg,   ST_IDLE);

`ifdef ELEV_DOOR_HOLD_EN
    // Door held for 20 cycles keeps it open for 20 + 8 cycles in total.
    do_reset();
    call(3'd0);
    tick();
    idle_inputs();
    tick();
    check("f_door_open", door_open, 1);
    door_hold = 1'b1;
    door_cycles = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 19) door_hold = 1'b0;
      if (!door_open) break;
      door_cycles++;
    end
    check("f_hold_cycles", door_cycles, 28);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/elevator_car_controller.md
ELEVATOR_CAR_CONTROLLER -- requirements
Module: elevator_car_controller

Interface
REQ-001 SHALL have parameter ELEV_ID, default 2'b01, the one-hot dispatch code this car answers to; 2'b10 selects the second car.
REQ-002 SHALL have parameter FLOOR_TICKS, default 4, the number of clock cycles to travel one floor (minimum 1).
REQ-003 SHALL have parameter DOOR_TICKS, default 8, the number of clock cycles the door stays open (minimum 1).
REQ-004 clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 dispatch_elev  input  2  one-hot car selection from the building dispatcher.
REQ-007 request_valid  input  1  hall request present this cycle.
REQ-008 request_floor  input  3  hall request floor.
REQ-009 request_dir  input  1  hall request direction: 1 = up, 0 = down.
REQ-010 car_call_valid  input  1  in-car button press.
REQ-011 car_call_floor  input  3  in-car requested floor.
REQ-012 request_ack  output  1  one-cycle pulse when a hall request has been accepted.
REQ-013 current_floor  output  3  floor of the car, fed back to the dispatcher.
REQ-014 current_dir  output  1  travel direction of the car (1 = up), fed back to the dispatcher.
REQ-015 door_open  output  1  high while the car is in DOOR_OPEN.
REQ-016 pending  output  8  bitmap of outstanding target floors, with bit n = floor n.

Function
REQ-017 A hall request SHALL be accepted when request_valid=1 and dispatch_elev==ELEV_ID; the car sets pending[request_floor] on the next edge and pulses request_ack for exactly one cycle on the cycle after acceptance.
REQ-018 A hall request with any other dispatch_elev value SHALL be ignored: no ack and no pending change.
REQ-019 A car call SHALL set pending[car_call_floor] on the next edge and SHALL NOT generate an ack.
REQ-020 A hall request and a car call in the same cycle SHALL both be recorded; setting a bit that is already set is a no-op.
REQ-021 The car SHALL use a four-state FSM: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
REQ-022 IDLE transitions SHALL be evaluated in this priority order:
- pending[current_floor] set -> DOOR_OPEN;
- else targets exist in current_dir -> move in current_dir;
- else targets exist in the opposite direction -> reverse current_dir and move;
- else remain in IDLE.
REQ-023 In MOVE_UP and MOVE_DOWN, a travel counter SHALL count FLOOR_TICKS cycles; on expiry current_floor changes by +1 or -1.
REQ-024 On arrival at a floor, if the pending bit for the new floor is set the FSM SHALL go to DOOR_OPEN; otherwise it continues if further targets lie ahead, else it goes to IDLE.
REQ-025 current_floor SHALL never exceed 7 or go below 0; MOVE_UP is never entered at floor 7 and MOVE_DOWN is never entered at floor 0.
REQ-026 On entry to DOOR_OPEN, pending[current_floor] SHALL clear; door_open=1 for exactly DOOR_TICKS cycles; the FSM then returns to IDLE.
REQ-027 A request for current_floor arriving while in DOOR_OPEN SHALL be absorbed: it is acked if it is a hall request, is never left in pending, and does not restart the door timer.
REQ-028 current_dir SHALL change only in IDLE (REQ-022) and SHALL hold its value in every other state.
REQ-029 A request for a floor the car is passing mid-travel SHALL be served if it is set before the counter for that floor expires.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL enter IDLE with current_floor=0, current_dir=1, pending=0, door_open=0, request_ack=0, and both counters at 0.
REQ-031 Reset asserted mid-travel or mid-door SHALL discard all pending requests and in-flight state, with no ack emitted.

Configuration
REQ-032 When ELEV_DOOR_HOLD_EN is defined, an input door_hold (1 bit) SHALL exist; while it is high in DOOR_OPEN the door counter reloads to DOOR_TICKS, so the door stays open until DOOR_TICKS cycles after door_hold deasserts.
REQ-033 When ELEV_DOOR_HOLD_EN is undefined, the door_hold port SHALL be absent and door timing SHALL follow REQ-026 exactly.

Structure
REQ-034 A shared package elevator_pkg SHALL hold:
- NUM_FLOORS=8, FLOOR_W=3;
- DIR_UP=1'b1, DIR_DOWN=1'b0;
- the car_state_t enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN).
REQ-035 A combinational sub-module, elevator_target_select, SHALL compute targets_above, targets_below and target_here from pending and current_floor.

Verification
REQ-036 Reset, then hall request floor 3 up with dispatch_elev=ELEV_ID -> ack one cycle later; MOVE_UP; current_floor=3 after 3*FLOOR_TICKS cycles; door_open for 8 cycles; pending=0.
REQ-037 Hall request with dispatch_elev=2'b10 to a car with ELEV_ID=2'b01 -> no ack; pending unchanged; car stays IDLE.
REQ-038 Car at floor 0 with car call 5; car call 2 injected while between floors 0 and 1 -> stops at 2 (door opens), then at 5; current_dir stays 1 throughout.
REQ-039 Car at floor 4, dir up, pending only bit 1 -> in IDLE current_dir flips to 0; arrives at floor 1 after 3*FLOOR_TICKS cycles.
REQ-040 Door open at floor 2, hall request floor 2 arrives -> acked; pending[2] stays 0; door closes on the original schedule.
REQ-041 rst_n low mid-travel between floors 3 and 4 -> next cycle current_floor=0, pending=0, IDLE; with ELEV_DOOR_HOLD_EN defined, door_hold held high for 20 cycles -> door_open high for 20+DOOR_TICKS cycles.
